div_unit_seq: RTL and testbench



---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 37 +++
 rtl/div_unit_seq.sv | 132 +++++++++++++
 tb/tb_div_unit_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential unsigned divider.
//   DIV_WIDTH    default operand/result width
//   div_state_e  FSM state encodings, visible to benches for state checks
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
//   rem_in / quo_in   current partial remainder R and quotient register Q
//   divisor           denominator
//   rem_out / quo_out {R,Q} after shift, trial subtract and restore select
// R is held in WIDTH bits: after every step R < divisor, so the extra bit of
// the WIDTH+1-bit partial remainder only ever exists transiently after the
// shift, where it takes part in the WIDTH+1-bit trial subtraction.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    always_comb begin
        // Left shift of {R,Q}: Q's MSB moves into R's LSB.
        shifted_rem = {rem_in, quo_in[WIDTH-1]};
        trial       = shifted_rem - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_out = trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            // Restore: the shifted remainder is below divisor, so its MSB is 0.
            rem_out = shifted_rem[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, reset_n      clock, asynchronous active-low reset
//   start             request, accepted only in IDLE
//   dividend/divisor  operands, captured when start is accepted
//   busy              high in RUN and DONE
//   done              one-cycle pulse, results valid from this cycle
//   quotient/remainder results, held until the next operation completes
//   div_by_zero       set with done when the captured divisor was 0
module div_unit_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_e state_q, state_d;

    logic [CntW-1:0]  count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DIV_DONE : DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (count_q == '0) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy = (state_q != DIV_IDLE);
        done = (state_q == DIV_DONE);
    end

    // Datapath: operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q       <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            divisor_q     <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient_q    <= '1;
                            remainder_q   <= dividend;
                            div_by_zero_q <= 1'b1;
                        end else begin
                            divisor_q     <= divisor;
                            rem_q         <= '0;
                            quo_q         <= dividend;
                            count_q       <= CntW'(WIDTH - 1);
                            div_by_zero_q <= 1'b0;
                        end
                    end
                end
                DIV_RUN: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (count_q == '0) begin
                        // Results land on entry to DONE.
                        quotient_q  <= quo_next;
                        remainder_q <= rem_next;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_unit_seq.sv
module tb_div_unit_seq;

    localparam int unsigned W = 32;

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic         start    = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;
    int t0       = 0;

    div_unit_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each accepted request completes a fixed number of
    // edges later with arithmetic results; busy spans request to done+1.
    logic         m_active = 1'b0;
    int           m_n      = 0;
    int           m_done_at = 0;
    logic [W-1:0] m_pq = '0, m_pr = '0;
    logic         m_pdbz = 1'b0;
    logic         exp_busy = 1'b0, exp_done = 1'b0, exp_dbz = 1'b0;
    logic [W-1:0] exp_q = '0, exp_r = '0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_active = 1'b0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
                exp_dbz  = 1'b0;
                exp_q    = '0;
                exp_r    = '0;
            end else begin
                m_n++;
                if (m_active) begin
                    if (m_n == m_done_at) begin
                        exp_done = 1'b1;
                        exp_q    = m_pq;
                        exp_r    = m_pr;
                        exp_dbz  = m_pdbz;
                    end else if (m_n == m_done_at + 1) begin
                        exp_done = 1'b0;
                        m_active = 1'b0;
                    end
                end else if (start) begin
                    m_active = 1'b1;
                    if (divisor == '0) begin
                        m_pq      = '1;
                        m_pr      = dividend;
                        m_pdbz    = 1'b1;
                        m_done_at = m_n;
                        exp_done  = 1'b1;
                        exp_q     = m_pq;
                        exp_r     = m_pr;
                        exp_dbz   = 1'b1;
                    end else begin
                        m_pq      = dividend / divisor;
                        m_pr      = dividend % divisor;
                        m_pdbz    = 1'b0;
                        m_done_at = m_n + W;
                        exp_dbz   = 1'b0;
                    end
                end
                exp_busy = m_active;
                #1;
                if (reset_n) begin
                    check("busy", W'(busy), W'(exp_busy));
                    check("done", W'(done), W'(exp_done));
                    check("div_by_zero", W'(div_by_zero), W'(exp_dbz));
                    check("quotient", quotient, exp_q);
                    check("remainder", remainder, exp_r);
                end
            end
        end
    end

    // Drive a request for one cycle; call at a negedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        t0       = edges + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Latency counts the start cycle: done after W edges gives W+1.
    task automatic wait_done(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edbz, input int elat);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: done not seen within 100 cycles", name);
        end else begin
            check({name, " latency"}, W'(edges - t0 + 1), W'(elat));
            check({name, " quotient"}, quotient, eq);
            check({name, " remainder"}, remainder, er);
            check({name, " div_by_zero"}, W'(div_by_zero), W'(edbz));
            @(negedge clk);
            check({name, " done pulse width"}, W'(done), '0);
            check({name, " busy after done"}, W'(busy), '0);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                          input int elat);
        @(negedge clk);
        issue(a, b);
        wait_done(name, eq, er, edbz, elat);
    endtask

    initial begin
        int pulses;
        #1;
        check("reset busy", W'(busy), '0);
        check("reset done", W'(done), '0);
        check("reset quotient", quotient, '0);
        check("reset remainder", remainder, '0);
        check("reset div_by_zero", W'(div_by_zero), '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_op("div0", 32'hDEADBEEF, 32'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1, 1);
        run_op("max/1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33);
        run_op("5/max", 32'd5, 32'hFFFFFFFF, 32'd0, 32'd5, 1'b0, 33);
        run_op("0/7", 32'd0, 32'd7, 32'd0, 32'd0, 1'b0, 33);
        run_op("1/2", 32'd1, 32'd2, 32'd0, 32'd1, 1'b0, 33);

        // Start while busy is ignored.
        @(negedge clk);
        issue(32'd100, 32'd7);
        repeat (8) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored start", 32'd14, 32'd2, 1'b0, 33);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("no second operation", W'(pulses), '0);

        // Reset mid-run aborts with no done.
        @(negedge clk);
        issue(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort busy", W'(busy), '0);
        check("abort done", W'(done), '0);
        check("abort quotient", quotient, '0);
        check("abort remainder", remainder, '0);
        check("abort div_by_zero", W'(div_by_zero), '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_op("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

        // Back-to-back with results held in IDLE.
        run_op("81/9", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33);
        check("hold quotient", quotient, 32'd9);
        check("hold remainder", remainder, 32'd0);
        issue(32'd17, 32'd5);
        wait_done("17/5", 32'd3, 32'd2, 1'b0, 33);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
